iter_mult_16: RTL and testbench

//  Iterative unsigned 16x16->32 shift-add multiplier for the EX stage. Each RUN

---
 rtl/iter_mult_16_pkg.sv | 31 +++
 rtl/iter_mult_16_cla.sv | 40 ++++
 rtl/iter_mult_16.sv | 119 +++++++++++
 tb/tb_iter_mult_16.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/iter_mult_16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iter_mult_16_pkg : shared FSM encodings, iteration count, CLA helpers       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package iter_mult_16_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int MULT_ITERS = 16;
  localparam int CNT_W_DEF  = 5;

  // Carry into each bit of a 4-bit lookahead group.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic ci);
    logic [3:0] c;
    c[0] = ci;
    for (int i = 1; i < 4; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    return c;
  endfunction

  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_mult_16_cla.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | CLA_16bit : two-level carry-lookahead adder, four 4-bit groups              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module CLA_16bit
  import iter_mult_16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      assign c[4*gi +: 4] = cla4_carries(g[4*gi +: 4], p[4*gi +: 4], grp_c[gi]);
      assign grp_g[gi]    = cla4_gen(g[4*gi +: 4], p[4*gi +: 4]);
      assign grp_p[gi]    = &p[4*gi +: 4];
    end
  endgenerate

  assign grp_c = cla4_carries(grp_g, grp_p, cin);
  assign cout  = cla4_gen(grp_g, grp_p) | (&grp_p & cin);
  assign sum   = p ^ c;

endmodule
`default_nettype wire

// File: rtl/iter_mult_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iter_mult_16 : iterative unsigned 16x16->32 shift-add multiplier           |
// | Optional macro MULT_EARLY_TERM_EN: zero operand skips RUN.                 |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module iter_mult_16
  import iter_mult_16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_s;
  logic               add_c;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               accept;
  logic               last_iter;
  logic               zero_op;

`ifdef MULT_EARLY_TERM_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign add_b = q_q[0] ? m_q : '0;

  CLA_16bit u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  // Adder carry drops straight into the accumulator MSB on the right shift.
  assign acc_nxt   = {add_c, add_s[WIDTH-1:1]};
  assign q_nxt     = {add_s[0], q_q[WIDTH-1:1]};
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (cnt_q == CNT_W'(MULT_ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = zero_op ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN:   if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_d    = m_q;
    acc_d  = acc_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (accept) begin
      m_d   = a;
      q_d   = b;
      acc_d = '0;
      cnt_d = '0;
      if (zero_op) prod_d = '0;
    end else if (state_q == S_RUN) begin
      acc_d = acc_nxt;
      q_d   = q_nxt;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) prod_d = {acc_nxt, q_nxt};
    end
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign prod = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_mult_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iter_mult_16 : scoreboard bench for iter_mult_16                        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_iter_mult_16;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] prod;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  iter_mult_16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [15:0] x, input logic [15:0] y);
    return (EARLY && (x == 16'h0 || y == 16'h0)) ? 1 : 16;
  endfunction

  function automatic exp_t mk_exp(input logic [15:0] x, input logic [15:0] y, input int c);
    exp_t e;
    e.prod = {16'h0, x} * {16'h0, y};
    e.cyc  = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("prod", prod, e.prod);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+#1 with the DUT idle; the next posedge is E0.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input bit expect_done);
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) exp_q.push_back(mk_exp(x, y, cyc + 1 + lat(x, y)));
    @(posedge clk); #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", prod, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic
    issue(16'd3, 16'd5, 1'b1);
    @(negedge clk);
    check("busy_in_run", busy, 1);
    check("no_done_in_run", done, 0);
    @(posedge clk); #1;
    wait_drain();
    check("busy_after", busy, 0);

    // max operands
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain();

    // second start while busy is ignored
    issue(16'd2, 16'd7, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    a = 16'd9; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    repeat (20) begin @(posedge clk); #1; end

    // reset mid-operation
    issue(16'd100, 16'd200, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_prod", prod, 0);
    rst = 1'b0;
    repeat (25) begin @(posedge clk); #1; end

    // back-to-back with start held
    a = 16'h1234; b = 16'h0010; start = 1'b1;
    exp_q.push_back(mk_exp(16'h1234, 16'h0010, cyc + 17));
    @(posedge clk); #1;
    exp_q.push_back(mk_exp(16'h8000, 16'h0002, cyc + 33));
    a = 16'h8000; b = 16'h0002;
    repeat (17) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_drain();

    // zero operands
    issue(16'h0000, 16'hABCD, 1'b1);
    wait_drain();
    issue(16'h5A5A, 16'h0000, 1'b1);
    wait_drain();

    // random operands
    for (int i = 0; i < 6; i++) begin
      issue(16'($urandom), 16'($urandom), 1'b1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
